// File: rtl/reg16_add16_datapath.sv
// rtl/reg16_add16_datapath.sv - 16-bit register-pair file with Add16 execution unit
// Holds PC/BC/DE/HL/SP/WZ, latches a microcode-selected operand and commits results.
module reg16_add16_datapath #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] RESET_SP = 16'h0000
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic [5:0]  i_Read16,
    input  logic [5:0]  i_Write16,
    input  logic [1:0]  i_Add16_Control,
    input  logic [15:0] i_Data16,
    output logic [15:0] o_Bus16,
    output logic [15:0] o_Operand,
    output logic [15:0] o_HL,
    output logic [15:0] o_SP,
    output logic [15:0] o_PC,
    output logic        o_Flag_H,
    output logic        o_Flag_C,
    output logic        o_Flag_Valid,
    output logic        o_Sel_Error
);

    localparam int PC_IDX = 0;
    localparam int BC_IDX = 1;
    localparam int DE_IDX = 2;
    localparam int HL_IDX = 3;
    localparam int SP_IDX = 4;
    localparam int WZ_IDX = 5;

    localparam logic [1:0] CTRL_LOAD = 2'b00;
    localparam logic [1:0] CTRL_INC  = 2'b01;
    localparam logic [1:0] CTRL_DEC  = 2'b10;
    localparam logic [1:0] CTRL_ADD  = 2'b11;

    logic [15:0] regs [6];
    logic [15:0] operand;
    logic        flag_h;
    logic        flag_c;
    logic        flag_valid;
    logic        sel_error;

    logic        read_onehot;
    logic        read_multi;
    logic        write_onehot;
    logic        write_multi;
    logic [2:0]  read_idx;
    logic [2:0]  write_idx;
    logic [15:0] bus;
    logic [15:0] result;
    logic [16:0] sum17;
    logic [12:0] half13;
    logic        add_commit;

    // x & (x-1) clears the lowest set bit; nonzero remainder means multi-hot
    always_comb begin
        read_multi   = (i_Read16 & (i_Read16 - 6'd1)) != 6'd0;
        write_multi  = (i_Write16 & (i_Write16 - 6'd1)) != 6'd0;
        read_onehot  = (i_Read16 != 6'd0) && !read_multi;
        write_onehot = (i_Write16 != 6'd0) && !write_multi;
    end

    always_comb begin
        read_idx  = 3'd0;
        write_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (i_Read16[i]) begin
                read_idx = 3'(i);
            end
            if (i_Write16[i]) begin
                write_idx = 3'(i);
            end
        end
    end

    always_comb begin
        bus = 16'h0000;
        if (read_onehot) begin
            bus = regs[read_idx];
        end
    end

    always_comb begin
        sum17  = {1'b0, regs[HL_IDX]} + {1'b0, operand};
        half13 = {1'b0, regs[HL_IDX][11:0]} + {1'b0, operand[11:0]};
        result = i_Data16;
        case (i_Add16_Control)
            CTRL_LOAD: result = i_Data16;
            CTRL_INC:  result = operand + 16'd1;
            CTRL_DEC:  result = operand - 16'd1;
            CTRL_ADD:  result = sum17[15:0];
            default:   result = i_Data16;
        endcase
    end

    assign add_commit = write_onehot && (i_Add16_Control == CTRL_ADD);

    // Operand and write target both see pre-edge values, so a same-edge
    // read of the written register returns the old contents.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < 6; i++) begin
                regs[i] <= 16'h0000;
            end
            regs[PC_IDX] <= RESET_PC;
            regs[SP_IDX] <= RESET_SP;
            operand      <= 16'h0000;
            flag_h       <= 1'b0;
            flag_c       <= 1'b0;
            flag_valid   <= 1'b0;
            sel_error    <= 1'b0;
        end else begin
            if (read_onehot) begin
                operand <= bus;
            end
            if (write_onehot) begin
                regs[write_idx] <= result;
            end
            if (add_commit) begin
                flag_h <= half13[12];
                flag_c <= sum17[16];
            end
            flag_valid <= add_commit;
            sel_error  <= read_multi || write_multi;
        end
    end

    assign o_Bus16      = bus;
    assign o_Operand    = operand;
    assign o_HL         = regs[HL_IDX];
    assign o_SP         = regs[SP_IDX];
    assign o_PC         = regs[PC_IDX];
    assign o_Flag_H     = flag_h;
    assign o_Flag_C     = flag_c;
    assign o_Flag_Valid = flag_valid;
    assign o_Sel_Error  = sel_error;

    // BC/DE/WZ are reachable only through the bus
    logic unused_idx;
    assign unused_idx = (BC_IDX == DE_IDX) || (WZ_IDX == 0);

endmodule

// File: tb/tb_reg16_add16_datapath.sv
// tb/tb_reg16_add16_datapath.sv - self-checking bench for reg16_add16_datapath
// Directed vector table, a reset-mid-add sequence, and random traffic against a model.
module tb_reg16_add16_datapath;

    logic        clk;
    logic        rst_n;
    logic [5:0]  rd;
    logic [5:0]  wr;
    logic [1:0]  ctrl;
    logic [15:0] data;
    logic [15:0] bus;
    logic [15:0] operand;
    logic [15:0] hl;
    logic [15:0] sp;
    logic [15:0] pc;
    logic        flag_h;
    logic        flag_c;
    logic        flag_valid;
    logic        sel_error;

    int passed = 0;
    int total  = 0;

    reg16_add16_datapath dut (
        .i_Clk          (clk),
        .i_Reset_n      (rst_n),
        .i_Read16       (rd),
        .i_Write16      (wr),
        .i_Add16_Control(ctrl),
        .i_Data16       (data),
        .o_Bus16        (bus),
        .o_Operand      (operand),
        .o_HL           (hl),
        .o_SP           (sp),
        .o_PC           (pc),
        .o_Flag_H       (flag_h),
        .o_Flag_C       (flag_c),
        .o_Flag_Valid   (flag_valid),
        .o_Sel_Error    (sel_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  rd;
        logic [5:0]  wr;
        logic [1:0]  ctrl;
        logic [15:0] data;
        logic [15:0] bus;
        logic [15:0] hl;
        logic [15:0] sp;
        logic [15:0] op;
        logic        h;
        logic        c;
        logic        fv;
        logic        err;
    } vec_t;

    vec_t vecs [26];

    // Behavioural model state
    logic [15:0] m_reg [6];
    logic [15:0] m_op;
    logic        m_h, m_c, m_fv, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] r, input logic [5:0] w, input logic [1:0] c,
                         input logic [15:0] d);
        rd   = r;
        wr   = w;
        ctrl = c;
        data = d;
    endtask

    function automatic int first_set(input logic [5:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [15:0] model_bus(input logic [5:0] r);
        if ($countones(r) == 1) return m_reg[first_set(r)];
        return 16'h0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_reg[i] = 16'h0000;
        m_op  = 16'h0000;
        m_h   = 1'b0;
        m_c   = 1'b0;
        m_fv  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic [5:0] r, input logic [5:0] w, input logic [1:0] c,
                              input logic [15:0] d);
        int opv = int'(m_op);
        int hlv = int'(m_reg[3]);
        int val;
        logic [15:0] next_op = m_op;
        if ($countones(r) == 1) next_op = m_reg[first_set(r)];
        m_fv = 1'b0;
        if ($countones(w) == 1) begin
            case (c)
                2'd0: val = int'(d);
                2'd1: val = (opv + 1) % 65536;
                2'd2: val = (opv + 65535) % 65536;
                default: begin
                    val  = (hlv + opv) % 65536;
                    m_c  = (hlv + opv) >= 65536;
                    m_h  = ((hlv % 4096) + (opv % 4096)) >= 4096;
                    m_fv = 1'b1;
                end
            endcase
            m_reg[first_set(w)] = 16'(val);
        end
        m_err = ($countones(r) > 1) || ($countones(w) > 1);
        m_op  = next_op;
    endtask

    function automatic logic [5:0] rand_sel();
        int k = $urandom_range(0, 9);
        logic [5:0] v;
        if (k == 0) return 6'd0;
        if (k == 1) begin
            v = 6'(1 << $urandom_range(0, 5));
            v = v | 6'(1 << ((first_set(v) + $urandom_range(1, 5)) % 6));
            return v;
        end
        return 6'(1 << $urandom_range(0, 5));
    endfunction

    initial begin
        //          rd     wr     c     data      bus      hl       sp       op       h     c     fv    err
        vecs[0]  = '{6'h00, 6'h08, 2'd0, 16'h0FFF, 16'h0000, 16'h0FFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{6'h00, 6'h02, 2'd0, 16'h0001, 16'h0000, 16'h0FFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{6'h02, 6'h00, 2'd0, 16'h0000, 16'h0001, 16'h0FFF, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{6'h00, 6'h08, 2'd3, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{6'h00, 6'h00, 2'd3, 16'hFFFF, 16'h0000, 16'h1000, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{6'h00, 6'h08, 2'd0, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{6'h00, 6'h10, 2'd0, 16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{6'h10, 6'h00, 2'd0, 16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{6'h00, 6'h08, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{6'h00, 6'h08, 2'd0, 16'h1234, 16'h0000, 16'h1234, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{6'h08, 6'h00, 2'd0, 16'h0000, 16'h1234, 16'h1234, 16'h8000, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{6'h00, 6'h08, 2'd3, 16'h0000, 16'h0000, 16'h2468, 16'h8000, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{6'h00, 6'h10, 2'd0, 16'hFFFF, 16'h0000, 16'h2468, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{6'h10, 6'h00, 2'd0, 16'h0000, 16'hFFFF, 16'h2468, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{6'h00, 6'h10, 2'd1, 16'h0000, 16'h0000, 16'h2468, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{6'h04, 6'h00, 2'd0, 16'h0000, 16'h0000, 16'h2468, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{6'h00, 6'h04, 2'd2, 16'h0000, 16'h0000, 16'h2468, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{6'h04, 6'h00, 2'd0, 16'h0000, 16'hFFFF, 16'h2468, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{6'h06, 6'h00, 2'd0, 16'h0000, 16'h0000, 16'h2468, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{6'h00, 6'h03, 2'd0, 16'h5555, 16'h0000, 16'h2468, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{6'h00, 6'h00, 2'd0, 16'h0000, 16'h0000, 16'h2468, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{6'h06, 6'h03, 2'd3, 16'h5555, 16'h0000, 16'h2468, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[22] = '{6'h00, 6'h00, 2'd0, 16'h0000, 16'h0000, 16'h2468, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{6'h02, 6'h00, 2'd0, 16'h0000, 16'h0001, 16'h2468, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[24] = '{6'h08, 6'h08, 2'd1, 16'h0000, 16'h2468, 16'h0002, 16'h0000, 16'h2468, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[25] = '{6'h08, 6'h00, 2'd0, 16'h0000, 16'h0002, 16'h0002, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(6'h00, 6'h00, 2'd0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hl", 32'(hl), 32'h0);
        check("reset_sp", 32'(sp), 32'h0);
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_op", 32'(operand), 32'h0);
        check("reset_flags", {28'h0, flag_h, flag_c, flag_valid, sel_error}, 32'h0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].ctrl, vecs[i].data);
            #2;
            check($sformatf("v%0d_bus", i), 32'(bus), 32'(vecs[i].bus));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_hl", i), 32'(hl), 32'(vecs[i].hl));
            check($sformatf("v%0d_sp", i), 32'(sp), 32'(vecs[i].sp));
            check($sformatf("v%0d_pc", i), 32'(pc), 32'h0);
            check($sformatf("v%0d_op", i), 32'(operand), 32'(vecs[i].op));
            check($sformatf("v%0d_hc", i), {30'h0, flag_h, flag_c}, {30'h0, vecs[i].h, vecs[i].c});
            check($sformatf("v%0d_fv", i), 32'(flag_valid), 32'(vecs[i].fv));
            check($sformatf("v%0d_err", i), 32'(sel_error), 32'(vecs[i].err));
        end

        // Reset between the read step and write step of an add
        drive(6'h00, 6'h08, 2'd0, 16'h0FFF);
        @(posedge clk); #1;
        drive(6'h00, 6'h02, 2'd0, 16'h0001);
        @(posedge clk); #1;
        drive(6'h02, 6'h00, 2'd0, 16'h0000);
        @(posedge clk); #1;
        check("mid_op_before", 32'(operand), 32'h0001);
        drive(6'h00, 6'h08, 2'd3, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_hl", 32'(hl), 32'h0);
        check("mid_async_op", 32'(operand), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(6'h00, 6'h00, 2'd0, 16'h0000);
        @(posedge clk); #1;
        check("mid_hl_after", 32'(hl), 32'h0);
        check("mid_flags_after", {29'h0, flag_h, flag_c, flag_valid}, 32'h0);
        drive(6'h02, 6'h00, 2'd0, 16'h0000);
        #2;
        check("mid_bc_cleared", 32'(bus), 32'h0);
        @(posedge clk); #1;

        // Random traffic against the model
        rst_n = 1'b0;
        drive(6'h00, 6'h00, 2'd0, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            logic [5:0]  r = rand_sel();
            logic [5:0]  w = rand_sel();
            logic [1:0]  c = 2'($urandom_range(0, 3));
            logic [15:0] d = 16'($urandom);
            drive(r, w, c, d);
            #2;
            check("rnd_bus", 32'(bus), 32'(model_bus(r)));
            model_step(r, w, c, d);
            @(posedge clk); #1;
            check("rnd_hl", 32'(hl), 32'(m_reg[3]));
            check("rnd_sp", 32'(sp), 32'(m_reg[4]));
            check("rnd_pc", 32'(pc), 32'(m_reg[0]));
            check("rnd_op", 32'(operand), 32'(m_op));
            check("rnd_flags", {28'h0, flag_h, flag_c, flag_valid, sel_error},
                  {28'h0, m_h, m_c, m_fv, m_err});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
